issue: RTL and testbench
========================

Name: issue

Overview:
- Front end of the Tomasulo core: instruction fetch, 4-entry instruction queue (IQ), decode, register renaming, ROB allocation and reservation-station dispatch.
- Sits between the 16-word instruction memory and the ROB / RS1 (add, sub) / RS2 (mul, div).
- Owns the PC, the IQ and the rename table (reg_valid, reg_rename).
- The register file, ROB storage and RS storage are external and accessed through ports.

Parameters:
- IQ_DEPTH, 4, instruction queue entries.
- NREG, 16, architectural registers; 4-bit specifiers.
- ROB_TAG_W, 3, ROB tag width (8 entries).
- RS_DEPTH, 4, entries per reservation station.

Ports:
- clk in 1: rising-edge clock.
- rst in 1: synchronous, active-high reset.
- imem_addr out 4: equals pc.
- imem_data in 16: combinational instruction read.
- rf_raddr_a, rf_raddr_b out 4: rs1 and rs2 fields of the IQ head.
- rf_rdata_a, rf_rdata_b in 8: register file read data.
- rob_qtag_a, rob_qtag_b out 3: reg_rename of rs1 and rs2.
- rob_qvalid_a, rob_qvalid_b in 1: ROB v_des of the queried entry.
- rob_qvalue_a, rob_qvalue_b in 8: ROB value of the queried entry.
- rob_tail in 3: next free ROB entry.
- rob_full in 1: ROB has no free entry.
- rob_alloc out 1: ROB allocation strobe.
- rob_alloc_opcode out 4, rob_alloc_dest out 4, rob_alloc_instr out 16: allocation payload.
- rs1_free, rs2_free in 4: free-entry masks, 1 = free.
- rs1_wr, rs2_wr out 1: RS write strobes.
- rs_wr_idx out 2: RS entry to write.
- rs_opcode out 4, rs_instr out 16: dispatched opcode and instruction.
- rs_src1_rdy, rs_src2_rdy out 1: 1 = operand holds a value, 0 = operand holds a ROB tag.
- rs_src1, rs_src2 out 8: operand value, or tag zero-extended.
- rs_dest out 3: destination ROB tag.
- commit_en in 1, commit_tag in 3, commit_reg in 4: ROB retirement notice.
- iq_count out 3, iq_full out 1, stall out 1, illegal_op out 1: status.

Behaviour:
- Instruction format: [15:12] opcode, [11:8] rd, [7:4] rs1, [3:0] rs2.
- Opcodes: 0000 sub, 0001 add → RS1; 0010 mul, 0011 div → RS2; any other opcode is illegal.
- Reset values: pc=0, fetch_done=0, IQ head=tail=count=0, all reg_valid=1, all reg_rename=0. All strobes and status outputs are 0.

Fetch (sequential):
- Condition: !fetch_done and IQ not full after this cycle's pop.
- Action: push imem_data into IQ and increment pc.
- Fetching address 15 sets fetch_done. pc does not wrap.

Issue (combinational decision on the registered IQ head, committed at the clock edge):
- Issue requires the IQ to be non-empty.
- Legal opcode: also requires !rob_full and a free entry in the target RS. The entry written is the lowest-index set bit of the free mask.
- Illegal opcode: the head is popped with no ROB allocation or RS write, and illegal_op pulses for one cycle.
- stall = IQ non-empty and a legal head cannot issue. The head is held.

Operand resolution, per source r:
- reg_valid[r]=1: rdy=1, value = rf_rdata.
- Else if rob_qvalid=1: rdy=1, value = rob_qvalue.
- Else: rdy=0, src = {5'b0, reg_rename[r]}.

On an issue edge:
- Sources are resolved from the pre-update rename table, so rd==rs is handled correctly.
- Then reg_valid[rd]=0 and reg_rename[rd]=rob_tail.
- rob_alloc, rs_dest=rob_tail and the dispatch payload are asserted in the same cycle.

Commit:
- If commit_en and reg_rename[commit_reg]==commit_tag, set reg_valid[commit_reg]=1.
- If the same cycle also issues with rd==commit_reg, the issue update wins.

IQ:
- Circular, 2-bit pointers, wrap-around.
- Simultaneous push and pop is legal and leaves the count unchanged.
- iq_full = (count==4).

Latency:
- The word at pc=0 is fetched on the first edge after reset, dispatched during cycle 1 and committed on the edge ending cycle 1.
- Throughput is 1 instruction per cycle.

Reset mid-operation clears the IQ, pc and rename table. Strobes drop in the same cycle.

Decomposition:
- Shared package: opcode constants (OP_SUB, OP_ADD, OP_MUL, OP_DIV, OP_ST, OP_LD) and width constants (instruction, register, data, ROB tag).
- One natural sub-module, issue_queue: the 4-entry circular FIFO with simultaneous push/pop.

Test Plan:
1. Reset, then memory word 0 = 16'h1312 (add r3,r1,r2) with reg_valid all 1 and rf returning 5 and 7 → cycle 1: rob_alloc=1, rs1_wr=1, rs_wr_idx=0, src1=5 rdy, src2=7 rdy, rs_dest=0; afterwards reg_valid[3]=0 and reg_rename[3]=0.
2. Words 16'h1312 then 16'h2433 (mul r4,r3,r3) with rob_qvalid=0 → mul dispatched to RS2 with src1=src2=tag 0 and rdy=0, dest=1. Repeat with rob_qvalid=1 and value 9 → src=9, rdy=1.
3. rob_full=1 held for 5 cycles → no rob_alloc, stall=1, iq_count reaches 4, iq_full=1, pc stops at 4. Release → resumes with no instruction lost or duplicated.
4. rs1_free=4'b0100 → rs_wr_idx=2. rs1_free=0 with an add at the head → stall=1 while a following mul waits behind it in order.
5. Commit tag 0 for r3 while reg_rename[3]=0 → reg_valid[3]=1. The same commit arriving after r3 has been renamed to tag 2 → reg_valid[3] stays 0.
6. Word 16'h5123 → illegal_op pulses for one cycle, no rob_alloc, IQ pops. After 16 fetches pc holds at 15 and fetch_done=1.

Source files
------------

// File: rtl/issue_pkg.sv
// Shared definitions for the Tomasulo issue front end.
// Latency: n/a (constants, types and pure helper functions only).
// Backpressure: n/a.
package issue_pkg;

   localparam int INSTR_W  = 16;
   localparam int OPC_W    = 4;
   localparam int REG_W    = 4;
   localparam int DATA_W   = 8;
   localparam int TAG_W    = 3;
   localparam int NREG     = 16;
   localparam int IQ_DEPTH = 4;
   localparam int RS_DEPTH = 4;

   localparam logic [OPC_W-1:0] OP_SUB = 4'b0000;
   localparam logic [OPC_W-1:0] OP_ADD = 4'b0001;
   localparam logic [OPC_W-1:0] OP_MUL = 4'b0010;
   localparam logic [OPC_W-1:0] OP_DIV = 4'b0011;
   // Memory ops are decoded elsewhere; this front end rejects them as illegal.
   localparam logic [OPC_W-1:0] OP_ST  = 4'b0100;
   localparam logic [OPC_W-1:0] OP_LD  = 4'b0101;

   typedef struct packed {
      logic [OPC_W-1:0] opcode;
      logic [REG_W-1:0] rd;
      logic [REG_W-1:0] rs1;
      logic [REG_W-1:0] rs2;
   } instr_t;

   typedef enum logic [1:0] {
      UNIT_RS1  = 2'd0,
      UNIT_RS2  = 2'd1,
      UNIT_NONE = 2'd2
   } unit_e;

   // Which reservation station an opcode goes to, or UNIT_NONE if illegal.
   function automatic unit_e op_unit(input logic [OPC_W-1:0] op);
      case (op)
         OP_SUB, OP_ADD: return UNIT_RS1;
         OP_MUL, OP_DIV: return UNIT_RS2;
         OP_ST, OP_LD:   return UNIT_NONE;
         default:        return UNIT_NONE;
      endcase
   endfunction

   // Index of the lowest set bit of a free mask (0 when the mask is empty).
   function automatic logic [1:0] lowest_free(input logic [RS_DEPTH-1:0] mask);
      logic [1:0] idx;
      idx = '0;
      for (int i = RS_DEPTH - 1; i >= 0; i--) begin
         if (mask[i]) idx = 2'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/issue_queue.sv
// Circular instruction queue with simultaneous push and pop.
// Latency: a pushed word is visible at the head on the cycle after the push edge.
// Backpressure: caller must not push when full unless it pops the same cycle.
module issue_queue
   import issue_pkg::*;
#(
   parameter int DEPTH = IQ_DEPTH,
   parameter int W     = INSTR_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_push,
   input  logic                     i_pop,
   input  logic [W-1:0]             i_dat,
   output logic [W-1:0]             o_head_dat,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_empty,
   output logic                     o_full
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [W-1:0]     r_mem [DEPTH];
   logic [PTR_W-1:0] r_head;
   logic [PTR_W-1:0] r_tail;
   logic [CNT_W-1:0] r_count;

   // Storage write; contents need no reset because count gates visibility.
   always_ff @(posedge clk) begin
      if (i_push) r_mem[r_tail] <= i_dat;
   end

   // Pointer and occupancy update; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (i_push) r_tail <= r_tail + 1'b1;
         if (i_pop)  r_head <= r_head + 1'b1;
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_head_dat = r_mem[r_head];
   assign o_count    = r_count;
   assign o_empty    = (r_count == '0);
   assign o_full     = (r_count == CNT_W'(DEPTH));

endmodule

// File: rtl/issue.sv
// Fetch, IQ, decode, rename, ROB allocation and RS dispatch for the Tomasulo core.
// Latency: word fetched on edge N is dispatched combinationally in cycle N+1.
// Backpressure: head holds (stall) on rob_full or no free RS entry; fetch stops when IQ full.
module issue
   import issue_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   output logic [3:0]           imem_addr,
   input  logic [INSTR_W-1:0]   imem_data,
   output logic [REG_W-1:0]     rf_raddr_a,
   output logic [REG_W-1:0]     rf_raddr_b,
   input  logic [DATA_W-1:0]    rf_rdata_a,
   input  logic [DATA_W-1:0]    rf_rdata_b,
   output logic [TAG_W-1:0]     rob_qtag_a,
   output logic [TAG_W-1:0]     rob_qtag_b,
   input  logic                 rob_qvalid_a,
   input  logic                 rob_qvalid_b,
   input  logic [DATA_W-1:0]    rob_qvalue_a,
   input  logic [DATA_W-1:0]    rob_qvalue_b,
   input  logic [TAG_W-1:0]     rob_tail,
   input  logic                 rob_full,
   output logic                 rob_alloc,
   output logic [OPC_W-1:0]     rob_alloc_opcode,
   output logic [REG_W-1:0]     rob_alloc_dest,
   output logic [INSTR_W-1:0]   rob_alloc_instr,
   input  logic [RS_DEPTH-1:0]  rs1_free,
   input  logic [RS_DEPTH-1:0]  rs2_free,
   output logic                 rs1_wr,
   output logic                 rs2_wr,
   output logic [1:0]           rs_wr_idx,
   output logic [OPC_W-1:0]     rs_opcode,
   output logic [INSTR_W-1:0]   rs_instr,
   output logic                 rs_src1_rdy,
   output logic                 rs_src2_rdy,
   output logic [DATA_W-1:0]    rs_src1,
   output logic [DATA_W-1:0]    rs_src2,
   output logic [TAG_W-1:0]     rs_dest,
   input  logic                 commit_en,
   input  logic [TAG_W-1:0]     commit_tag,
   input  logic [REG_W-1:0]     commit_reg,
   output logic [2:0]           iq_count,
   output logic                 iq_full,
   output logic                 stall,
   output logic                 illegal_op
);

   logic [3:0]          r_pc;
   logic                r_fetch_done;
   logic [NREG-1:0]     r_reg_valid;
   logic [TAG_W-1:0]    r_reg_rename [NREG];

   logic [INSTR_W-1:0]  w_head;
   instr_t              w_hd;
   logic                w_empty;
   logic                w_full;
   unit_e               w_unit;
   logic                w_legal;
   logic [RS_DEPTH-1:0] w_free;
   logic                w_blocked;
   logic                w_issue;
   logic                w_illegal;
   logic                w_pop;
   logic                w_push;

   issue_queue #(.DEPTH(IQ_DEPTH), .W(INSTR_W)) u_iq (
      .clk        (clk),
      .rst        (rst),
      .i_push     (w_push),
      .i_pop      (w_pop),
      .i_dat      (imem_data),
      .o_head_dat (w_head),
      .o_count    (iq_count),
      .o_empty    (w_empty),
      .o_full     (w_full)
   );

   assign w_hd = w_head;

   // Decode the head and decide issue / illegal drop; all strobes are killed by rst.
   always_comb begin
      w_unit    = op_unit(w_hd.opcode);
      w_legal   = (w_unit != UNIT_NONE);
      w_free    = (w_unit == UNIT_RS2) ? rs2_free : rs1_free;
      w_blocked = rob_full || (w_free == '0);
      w_issue   = !rst && !w_empty && w_legal && !w_blocked;
      w_illegal = !rst && !w_empty && !w_legal;
      w_pop     = w_issue || w_illegal;
      // A full queue can still accept a word when the head leaves this cycle.
      w_push    = !rst && !r_fetch_done && (!w_full || w_pop);
   end

   // Resolve both sources from the pre-update rename table.
   always_comb begin
      rs_src1_rdy = 1'b1;
      rs_src1     = rf_rdata_a;
      if (!r_reg_valid[w_hd.rs1]) begin
         if (rob_qvalid_a) begin
            rs_src1 = rob_qvalue_a;
         end else begin
            rs_src1_rdy = 1'b0;
            rs_src1     = {{(DATA_W-TAG_W){1'b0}}, r_reg_rename[w_hd.rs1]};
         end
      end
      rs_src2_rdy = 1'b1;
      rs_src2     = rf_rdata_b;
      if (!r_reg_valid[w_hd.rs2]) begin
         if (rob_qvalid_b) begin
            rs_src2 = rob_qvalue_b;
         end else begin
            rs_src2_rdy = 1'b0;
            rs_src2     = {{(DATA_W-TAG_W){1'b0}}, r_reg_rename[w_hd.rs2]};
         end
      end
   end

   assign imem_addr        = r_pc;
   assign rf_raddr_a       = w_hd.rs1;
   assign rf_raddr_b       = w_hd.rs2;
   assign rob_qtag_a       = r_reg_rename[w_hd.rs1];
   assign rob_qtag_b       = r_reg_rename[w_hd.rs2];

   assign rob_alloc        = w_issue;
   assign rob_alloc_opcode = w_hd.opcode;
   assign rob_alloc_dest   = w_hd.rd;
   assign rob_alloc_instr  = w_head;

   assign rs1_wr           = w_issue && (w_unit == UNIT_RS1);
   assign rs2_wr           = w_issue && (w_unit == UNIT_RS2);
   assign rs_wr_idx        = lowest_free(w_free);
   assign rs_opcode        = w_hd.opcode;
   assign rs_instr         = w_head;
   assign rs_dest          = rob_tail;

   assign iq_full          = w_full;
   assign stall            = !rst && !w_empty && w_legal && w_blocked;
   assign illegal_op       = w_illegal;

   // Program counter: advances on every fetch and parks at 15 once it is fetched.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc         <= '0;
         r_fetch_done <= 1'b0;
      end else if (w_push) begin
         if (r_pc == 4'd15) r_fetch_done <= 1'b1;
         else               r_pc         <= r_pc + 4'd1;
      end
   end

   // Rename table: commit marks a register valid, a same-cycle issue to it overrides.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_reg_valid <= '1;
         for (int i = 0; i < NREG; i++) r_reg_rename[i] <= '0;
      end else begin
         if (commit_en && (r_reg_rename[commit_reg] == commit_tag))
            r_reg_valid[commit_reg] <= 1'b1;
         if (w_issue) begin
            r_reg_valid[w_hd.rd]  <= 1'b0;
            r_reg_rename[w_hd.rd] <= rob_tail;
         end
      end
   end

endmodule

// File: tb/tb_issue.sv
// Randomized bench for the issue front end against a queue-based reference model.
// Each cycle: drive inputs after the rising edge, compare on the falling edge, advance the model.
// Memory, register file and ROB lookups are modelled by combinational responders.
module tb_issue;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [3:0]  imem_addr;
   logic [15:0] imem_data;
   logic [3:0]  rf_raddr_a, rf_raddr_b;
   logic [7:0]  rf_rdata_a, rf_rdata_b;
   logic [2:0]  rob_qtag_a, rob_qtag_b;
   logic        rob_qvalid_a, rob_qvalid_b;
   logic [7:0]  rob_qvalue_a, rob_qvalue_b;
   logic [2:0]  rob_tail;
   logic        rob_full;
   logic        rob_alloc;
   logic [3:0]  rob_alloc_opcode, rob_alloc_dest;
   logic [15:0] rob_alloc_instr;
   logic [3:0]  rs1_free, rs2_free;
   logic        rs1_wr, rs2_wr;
   logic [1:0]  rs_wr_idx;
   logic [3:0]  rs_opcode;
   logic [15:0] rs_instr;
   logic        rs_src1_rdy, rs_src2_rdy;
   logic [7:0]  rs_src1, rs_src2;
   logic [2:0]  rs_dest;
   logic        commit_en;
   logic [2:0]  commit_tag;
   logic [3:0]  commit_reg;
   logic [2:0]  iq_count;
   logic        iq_full, stall, illegal_op;

   issue dut (
      .clk(clk), .rst(rst),
      .imem_addr(imem_addr), .imem_data(imem_data),
      .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
      .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
      .rob_qtag_a(rob_qtag_a), .rob_qtag_b(rob_qtag_b),
      .rob_qvalid_a(rob_qvalid_a), .rob_qvalid_b(rob_qvalid_b),
      .rob_qvalue_a(rob_qvalue_a), .rob_qvalue_b(rob_qvalue_b),
      .rob_tail(rob_tail), .rob_full(rob_full),
      .rob_alloc(rob_alloc), .rob_alloc_opcode(rob_alloc_opcode),
      .rob_alloc_dest(rob_alloc_dest), .rob_alloc_instr(rob_alloc_instr),
      .rs1_free(rs1_free), .rs2_free(rs2_free),
      .rs1_wr(rs1_wr), .rs2_wr(rs2_wr), .rs_wr_idx(rs_wr_idx),
      .rs_opcode(rs_opcode), .rs_instr(rs_instr),
      .rs_src1_rdy(rs_src1_rdy), .rs_src2_rdy(rs_src2_rdy),
      .rs_src1(rs_src1), .rs_src2(rs_src2), .rs_dest(rs_dest),
      .commit_en(commit_en), .commit_tag(commit_tag), .commit_reg(commit_reg),
      .iq_count(iq_count), .iq_full(iq_full), .stall(stall), .illegal_op(illegal_op)
   );

   // Environment storage behind the combinational read ports.
   logic [15:0] mem    [16];
   logic [7:0]  rf_mem [16];
   logic        robv   [8];
   logic [7:0]  robval [8];

   assign imem_data    = mem[imem_addr];
   assign rf_rdata_a   = rf_mem[rf_raddr_a];
   assign rf_rdata_b   = rf_mem[rf_raddr_b];
   assign rob_qvalid_a = robv[rob_qtag_a];
   assign rob_qvalid_b = robv[rob_qtag_b];
   assign rob_qvalue_a = robval[rob_qtag_a];
   assign rob_qvalue_b = robval[rob_qtag_b];

   // Reference model state.
   int          m_pc;
   bit          m_fd;
   logic [15:0] m_q [$];
   bit          m_val [16];
   logic [2:0]  m_ren [16];

   int n_cmp = 0;
   int n_bad = 0;
   int p_full;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pc = 0;
      m_fd = 0;
      m_q.delete();
      for (int i = 0; i < 16; i++) begin
         m_val[i] = 1;
         m_ren[i] = 3'd0;
      end
   endtask

   // Architectural operand lookup: register file, else completed ROB value, else tag.
   task automatic resolve(input logic [3:0] r, output logic rdy, output logic [7:0] v);
      if (m_val[r]) begin
         rdy = 1'b1; v = rf_mem[r];
      end else if (robv[m_ren[r]]) begin
         rdy = 1'b1; v = robval[m_ren[r]];
      end else begin
         rdy = 1'b0; v = {5'b0, m_ren[r]};
      end
   endtask

   task automatic check_cycle();
      logic [15:0] h;
      logic [3:0]  op, fm;
      logic        empty, legal, can, r1, r2;
      logic [7:0]  v1, v2;
      int          idx;
      bit          pop;
      if (rst) begin
         check("rst_rob_alloc", rob_alloc, 0);
         check("rst_rs1_wr", rs1_wr, 0);
         check("rst_rs2_wr", rs2_wr, 0);
         check("rst_stall", stall, 0);
         check("rst_illegal", illegal_op, 0);
         model_reset();
         return;
      end
      empty = (m_q.size() == 0);
      check("imem_addr", imem_addr, m_pc);
      check("iq_count", iq_count, m_q.size());
      check("iq_full", iq_full, m_q.size() == 4);
      h     = empty ? 16'h0 : m_q[0];
      op    = h[15:12];
      legal = (op < 4);
      fm    = (op >= 2) ? rs2_free : rs1_free;
      can   = !empty && legal && !rob_full && (fm != 0);
      check("rob_alloc", rob_alloc, can);
      check("rs1_wr", rs1_wr, can && op < 2);
      check("rs2_wr", rs2_wr, can && op >= 2);
      check("illegal_op", illegal_op, !empty && !legal);
      check("stall", stall, !empty && legal && !can);
      if (!empty) begin
         check("rob_qtag_a", rob_qtag_a, m_ren[h[7:4]]);
         check("rob_qtag_b", rob_qtag_b, m_ren[h[3:0]]);
      end
      if (can) begin
         idx = 0;
         while (!fm[idx]) idx++;
         check("rs_wr_idx", rs_wr_idx, idx);
         check("rs_opcode", rs_opcode, op);
         check("rs_instr", rs_instr, h);
         check("rs_dest", rs_dest, rob_tail);
         check("alloc_opcode", rob_alloc_opcode, op);
         check("alloc_dest", rob_alloc_dest, h[11:8]);
         check("alloc_instr", rob_alloc_instr, h);
         resolve(h[7:4], r1, v1);
         resolve(h[3:0], r2, v2);
         check("src1_rdy", rs_src1_rdy, r1);
         check("src1", rs_src1, v1);
         check("src2_rdy", rs_src2_rdy, r2);
         check("src2", rs_src2, v2);
      end
      // Advance the model across the coming edge.
      pop = !empty && (can || !legal);
      if (commit_en && m_ren[commit_reg] == commit_tag) m_val[commit_reg] = 1;
      if (can) begin
         m_val[h[11:8]] = 0;
         m_ren[h[11:8]] = rob_tail;
      end
      if (pop) void'(m_q.pop_front());
      if (!m_fd && m_q.size() < 4) begin
         m_q.push_back(mem[m_pc]);
         if (m_pc == 15) m_fd = 1;
         else            m_pc++;
      end
   endtask

   function automatic logic [15:0] rand_word();
      int         r;
      logic [3:0] op;
      r  = $urandom_range(0, 9);
      op = (r < 8) ? 4'(r % 4) : 4'($urandom_range(4, 15));
      return {op, 4'($urandom_range(0, 5)), 4'($urandom_range(0, 5)), 4'($urandom_range(0, 5))};
   endfunction

   initial begin
      rst = 1'b1; rob_full = 1'b0; rob_tail = '0;
      rs1_free = '1; rs2_free = '1;
      commit_en = 1'b0; commit_tag = '0; commit_reg = '0;
      for (int i = 0; i < 16; i++) begin
         mem[i] = '0; rf_mem[i] = '0;
      end
      for (int i = 0; i < 8; i++) begin
         robv[i] = 1'b0; robval[i] = '0;
      end
      model_reset();
      for (int ep = 0; ep < 25; ep++) begin
         p_full = $urandom_range(0, 3);
         for (int cyc = 0; cyc < 45; cyc++) begin
            rst = (cyc == 0) || ($urandom_range(0, 63) == 0);
            if (cyc == 0) begin
               for (int i = 0; i < 16; i++) mem[i] = rand_word();
               if (ep == 0) begin
                  mem[0] = 16'h1312;
                  mem[1] = 16'h2433;
                  mem[2] = 16'h5123;
               end
            end
            for (int i = 0; i < 16; i++) rf_mem[i] = 8'($urandom);
            for (int i = 0; i < 8; i++) begin
               robv[i]   = ($urandom_range(0, 1) == 1);
               robval[i] = 8'($urandom);
            end
            rob_full   = ($urandom_range(0, 4) < p_full);
            rob_tail   = 3'($urandom);
            rs1_free   = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
            rs2_free   = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
            commit_en  = ($urandom_range(0, 1) == 1);
            commit_reg = 4'($urandom_range(0, 5));
            commit_tag = ($urandom_range(0, 1) == 1) ? m_ren[commit_reg] : 3'($urandom);
            @(negedge clk);
            check_cycle();
            @(posedge clk);
            #1;
         end
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
